// File: rtl/apb_exe_pkg.sv
// Shared types and register map for the APB execution-unit master.
// Latency: n/a (declarations only). Backpressure: n/a.
// Used by apb_exe_master and apb_wdog.
package apb_exe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_SLVERR  = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_e;

    localparam logic [7:0] ADDR_ARG_A  = 8'h00;
    localparam logic [7:0] ADDR_ARG_B  = 8'h04;
    localparam logic [7:0] ADDR_OP     = 8'h08;
    localparam logic [7:0] ADDR_RESULT = 8'h0C;
    localparam logic [7:0] ADDR_STAT   = 8'h10;

    localparam int STAT_EVEN     = 0;
    localparam int STAT_ONES     = 1;
    localparam int STAT_OVERFLOW = 2;
    localparam int STAT_ERROR    = 3;

    localparam logic [2:0] XFER_RESULT = 3'd3;
    localparam logic [2:0] XFER_STAT   = 3'd4;
    localparam logic [2:0] XFER_LAST   = 3'd4;

    // Fixed transfer sequence: ARG_A, ARG_B, OP writes, then RESULT, STAT reads.
    function automatic logic [7:0] xfer_addr(input logic [2:0] k);
        case (k)
            3'd0:    return ADDR_ARG_A;
            3'd1:    return ADDR_ARG_B;
            3'd2:    return ADDR_OP;
            3'd3:    return ADDR_RESULT;
            default: return ADDR_STAT;
        endcase
    endfunction

    function automatic logic xfer_is_write(input logic [2:0] k);
        return k < XFER_RESULT;
    endfunction

endpackage

// File: rtl/apb_exe_master_if.sv
// Command/response stream plus APB bus of the execution-unit master.
// Latency: n/a (wiring only). Backpressure: valid/ready on cmd and rsp, pready on APB.
// master modport is the initiator side, slave modport the host + APB target side.
interface apb_exe_master_if #(
    parameter int M  = 8,
    parameter int N  = 2,
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic [N-1:0]  i_cmd_op;
    logic [M-1:0]  i_cmd_argA;
    logic [M-1:0]  i_cmd_argB;
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [M-1:0]  o_rsp_result;
    logic [3:0]    o_rsp_stat;
    logic [1:0]    o_rsp_err;
    logic [AW-1:0] o_paddr;
    logic          o_psel;
    logic          o_penable;
    logic          o_pwrite;
    logic [DW-1:0] o_pwdata;
    logic [DW-1:0] i_prdata;
    logic          i_pready;
    logic          i_pslverr;

    modport master (
        input  i_cmd_valid, i_cmd_op, i_cmd_argA, i_cmd_argB, i_rsp_ready,
               i_prdata, i_pready, i_pslverr,
        output o_cmd_ready, o_rsp_valid, o_rsp_result, o_rsp_stat, o_rsp_err,
               o_paddr, o_psel, o_penable, o_pwrite, o_pwdata
    );

    modport slave (
        output i_cmd_valid, i_cmd_op, i_cmd_argA, i_cmd_argB, i_rsp_ready,
               i_prdata, i_pready, i_pslverr,
        input  o_cmd_ready, o_rsp_valid, o_rsp_result, o_rsp_stat, o_rsp_err,
               o_paddr, o_psel, o_penable, o_pwrite, o_pwdata
    );
endinterface

// File: rtl/apb_wdog.sv
// Wait-state watchdog for one APB transfer; compiled only with APB_MASTER_TIMEOUT_EN.
// Latency: o_expired is combinational in the LIMIT-th counted wait cycle. Backpressure: none.
// Counter clears on i_clr and advances on i_cnt.
`ifdef APB_MASTER_TIMEOUT_EN
module apb_wdog #(
    parameter int LIMIT = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_cnt,
    output logic o_expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_cnt) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires in the wait cycle that brings the count to LIMIT, so the bus drops at that edge.
    assign o_expired = i_cnt && (cnt_q == CW'(LIMIT - 1));
endmodule
`endif

// File: rtl/apb_exe_master.sv
// APB initiator: one command -> ARG_A/ARG_B/OP writes, RESULT/STAT reads -> one response.
// Latency: response 11 cycles after command accept with zero wait states, +1 per wait state.
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready. Macro APB_MASTER_TIMEOUT_EN.
module apb_exe_master
    import apb_exe_pkg::*;
#(
    parameter int M         = 8,
    parameter int N         = 2,
    parameter int AW        = 8,
    parameter int DW        = 32,
    parameter int TO_CYCLES = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    apb_exe_master_if.master  bus
);
    state_e       state_q, state_d;
    logic [2:0]   k_q, k_d;
    logic [N-1:0] op_q, op_d;
    logic [M-1:0] a_q, a_d;
    logic [M-1:0] b_q, b_d;
    logic [M-1:0] result_q, result_d;
    logic [3:0]   stat_q, stat_d;
    err_e         err_q, err_d;
    logic         to_expired;
    logic         active;
    logic         unused_prdata;

    assign unused_prdata = ^bus.i_prdata;

`ifdef APB_MASTER_TIMEOUT_EN
    apb_wdog #(
        .LIMIT (TO_CYCLES)
    ) u_wdog (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clr     (state_q == ST_SETUP),
        .i_cnt     ((state_q == ST_ACCESS) && !bus.i_pready),
        .o_expired (to_expired)
    );
`else
    logic unused_to;
    assign unused_to  = (TO_CYCLES == 0);
    assign to_expired = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        stat_d   = stat_q;
        err_d    = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_cmd_valid) begin
                    op_d     = bus.i_cmd_op;
                    a_d      = bus.i_cmd_argA;
                    b_d      = bus.i_cmd_argB;
                    k_d      = 3'd0;
                    result_d = '0;
                    stat_d   = '0;
                    err_d    = ERR_OK;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (bus.i_pready) begin
                    if (bus.i_pslverr) begin
                        // Abort: a RESULT captured earlier must not leak into an error response.
                        err_d    = ERR_SLVERR;
                        result_d = '0;
                        stat_d   = '0;
                        state_d  = ST_RESP;
                    end else begin
                        if (k_q == XFER_RESULT) begin
                            result_d = bus.i_prdata[M-1:0];
                        end
                        if (k_q == XFER_STAT) begin
                            stat_d = {bus.i_prdata[STAT_ERROR], bus.i_prdata[STAT_OVERFLOW],
                                      bus.i_prdata[STAT_ONES], bus.i_prdata[STAT_EVEN]};
                        end
                        if (k_q == XFER_LAST) begin
                            state_d = ST_RESP;
                        end else begin
                            k_d     = k_q + 3'd1;
                            state_d = ST_SETUP;
                        end
                    end
                end else if (to_expired) begin
                    err_d    = ERR_TIMEOUT;
                    result_d = '0;
                    stat_d   = '0;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q  <= ST_IDLE;
            k_q      <= 3'd0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            stat_q   <= '0;
            err_q    <= ERR_OK;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            stat_q   <= stat_d;
            err_q    <= err_d;
        end
    end

    assign active           = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign bus.o_cmd_ready  = (state_q == ST_IDLE);
    assign bus.o_rsp_valid  = (state_q == ST_RESP);
    assign bus.o_rsp_result = result_q;
    assign bus.o_rsp_stat   = stat_q;
    assign bus.o_rsp_err    = err_q;
    assign bus.o_psel       = active;
    assign bus.o_penable    = (state_q == ST_ACCESS);
    assign bus.o_pwrite     = active && xfer_is_write(k_q);
    assign bus.o_paddr      = active ? AW'(xfer_addr(k_q)) : '0;

    always_comb begin
        bus.o_pwdata = '0;
        if (active) begin
            case (k_q)
                3'd0:    bus.o_pwdata = DW'(a_q);
                3'd1:    bus.o_pwdata = DW'(b_q);
                3'd2:    bus.o_pwdata = DW'(op_q);
                default: bus.o_pwdata = '0;
            endcase
        end
    end
endmodule

// File: doc/apb_exe_master.md
# apb_exe_master

APB initiator that drives the memory-mapped execution unit from a simple command/response stream. It accepts one command per handshake (operation code plus two operands) and issues a fixed sequence of five APB transfers: write ARG_A, write ARG_B, write OP, read RESULT, read STAT. It then returns the result, status flags and an error code on a response handshake. It sits between the test/host logic and the APB slave wrapper of the execution unit.

## Interface
Parameters:
- M, 8: operand/result width (M ≤ DW)
- N, 2: operation-code width
- AW, 8: APB address width
- DW, 32: APB data width
- TO_CYCLES, 16: wait-state limit per transfer (used only with the timeout feature)

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_reset  in  1  reset, synchronous, active-low
- i_cmd_valid  in  1  command present
- o_cmd_ready  out  1  master can accept a command
- i_cmd_op  in  N  operation code
- i_cmd_argA  in  M  operand A
- i_cmd_argB  in  M  operand B
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  consumer takes response
- o_rsp_result  out  M  RESULT register value
- o_rsp_stat  out  4  STAT flags {ERROR, OVERFLOW, ONES, EVEN}
- o_rsp_err  out  2  00 ok, 01 slave error, 10 timeout
- o_paddr  out  AW  APB address
- o_psel  out  1  APB select
- o_penable  out  1  APB enable
- o_pwrite  out  1  APB direction
- o_pwdata  out  DW  APB write data
- i_prdata  in  DW  APB read data
- i_pready  in  1  APB ready
- i_pslverr  in  1  APB slave error

## Operation
- Register map (byte addresses): ARG_A 0x00, ARG_B 0x04, OP 0x08, RESULT 0x0C, STAT 0x10.
- Reset (i_reset=0 at an edge): state IDLE. All outputs 0 except o_cmd_ready=1.
- FSM states and transitions:
  - IDLE: o_cmd_ready=1. On i_cmd_valid, latch op/argA/argB, set xfer index k=0, go to SETUP.
  - SETUP: o_psel=1, o_penable=0, address/direction/data for k. Go to ACCESS.
  - ACCESS: o_psel=1, o_penable=1, same address/data as SETUP.
    - On i_pready=1 with i_pslverr=1: go to RESP with err=01.
    - On i_pready=1 otherwise: capture read data if k is 3 or 4. Then k==4 goes to RESP with err=00; else k+1 and SETUP.
    - On i_pready=0: stay in ACCESS.
  - RESP: o_rsp_valid=1, APB idle. On i_rsp_ready go to IDLE.
- Write data: zero-extended operand or op to DW bits. Reads use o_pwdata=0.
- Captured fields:
  - o_rsp_result = i_prdata[M-1:0] of the RESULT read.
  - o_rsp_stat = i_prdata[3:0] of the STAT read.
- On any error, the remaining transfers are skipped and o_rsp_result and o_rsp_stat are 0.
- Response outputs are held stable while o_rsp_valid=1 and i_rsp_ready=0.

## Timing
- Command accepted at edge T. Transfer k SETUP is cycle T+1+2k; ACCESS is T+2+2k (zero wait states).
- Zero wait states: o_rsp_valid rises at T+11. The next command can be accepted in the cycle after the i_rsp_ready handshake.
- Each wait state adds one cycle.
- The one-cycle gap between the OP write completing and the RESULT read ACCESS covers the execution unit's registered output. No extra wait is inserted.
- Reset mid-transfer: o_psel and o_penable are 0 after the next edge. The latched command is discarded and no response is produced.
- o_cmd_ready is 0 in every state except IDLE, so commands cannot overlap.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A counter clears on entry to ACCESS and increments on each cycle with i_pready=0.
  - When it reaches TO_CYCLES, the transfer is abandoned: psel/penable drop at the next edge, state goes to RESP, err=10, result and stat are 0.
- Undefined: no counter, ACCESS waits indefinitely, and o_rsp_err[1] is constant 0.

## Structure
- Package apb_exe_pkg:
  - FSM state enum (IDLE, SETUP, ACCESS, RESP)
  - register address localparams
  - error-code enum
  - STAT bit-index constants
- Sub-module apb_wdog: the wait-state counter with clear, count and expired signals. It is instantiated only under APB_MASTER_TIMEOUT_EN.

## Test plan
- Basic command: op=2'b01, argA=8'h0F, argB=8'h02, slave with no wait states returning RESULT 0x3C and STAT 0x1. Required:
  - writes 0x0F@0x00, 0x02@0x04, 0x1@0x08, then reads 0x0C and 0x10
  - o_rsp_valid at T+11 with result=8'h3C, stat=4'h1, err=00
- Slave inserts 3 wait states on the OP write: o_penable stays high 4 cycles at 0x08 with address/data stable; o_rsp_valid at T+14.
- i_pslverr=1 on the ARG_B write: no OP write or reads follow; response has err=01, result=0, stat=0.
- i_rsp_ready held low 5 cycles, new i_cmd_valid asserted: response holds stable, o_cmd_ready=0, and no APB activity until the response handshake.
- i_reset=0 during the RESULT read ACCESS: next edge gives psel=0, penable=0, o_cmd_ready=1, o_rsp_valid=0.
- APB_MASTER_TIMEOUT_EN, TO_CYCLES=16, i_pready stuck 0 on the STAT read: abort after 16 wait cycles with err=10, then a following normal command completes with err=00.
